ram_loader: RTL and testbench

//  Upstream write master for the FRANK6000 RAM. Accepts a framed byte stream

---
 rtl/ram_loader.sv | 114 +++++++++++
 tb/tb_ram_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader: writes a framed valid/ready byte stream (LEN, BASE, payload, CSUM) into RAM,
// holding the CPU off the RAM port while loading and flagging checksum errors.
module ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [2:0] {IDLE, LEN, BASE, DATA, CSUM, DONE, ERR} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d, cnt_q, cnt_d, cnt_inc;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d, ram_din_q, ram_din_d, csum_chk;
    logic                  ram_we_q, ram_we_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                  xfer, arm;
    assign in_ready = state_q inside {LEN, BASE, DATA, CSUM};
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_we   = ram_we_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    always_comb begin
        xfer       = in_valid & in_ready;
        arm        = start & (state_q inside {IDLE, DONE, ERR});
        cnt_inc    = cnt_q + 1'b1;
        csum_chk   = sum_q + in_data;
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sum_d      = sum_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_we_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        err_d      = err_q;
        if (arm) begin
            state_d = LEN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (xfer) begin
            case (state_q)
                LEN: begin
                    // LEN of zero means the whole address space
                    len_d   = {in_data[ADDR_WIDTH-1:0] == '0, in_data[ADDR_WIDTH-1:0]};
                    state_d = BASE;
                end
                BASE: begin
                    addr_d  = in_data[ADDR_WIDTH-1:0];
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = DATA;
                end
                DATA: begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = addr_q;
                    ram_din_d  = in_data;
                    addr_d     = addr_q + 1'b1;
                    sum_d      = csum_chk;
                    cnt_d      = cnt_inc;
                    state_d    = (cnt_inc == len_q) ? CSUM : DATA;
                end
                CSUM: begin
                    busy_d  = 1'b0;
                    done_d  = csum_chk == '0;
                    err_d   = csum_chk != '0;
                    state_d = (csum_chk == '0) ? DONE : ERR;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            sum_q      <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sum_q      <= sum_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_we_q   <= ram_we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: frame-level scenarios and randomized frames checked against a
// RAM-write reference model derived from the frame rules.
module tb_ram_loader;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, ram_we, busy, done, err;
    logic [7:0] ram_addr, ram_din;
    int         checks = 0, passed = 0, rdy_cnt = 0;
    logic [7:0] mem [256];
    logic [7:0] got_a[$], got_d[$], pl[$];

    ram_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model and write/ready monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (ram_we) begin
            mem[ram_addr] = ram_din;
            got_a.push_back(ram_addr);
            got_d.push_back(ram_din);
        end
        if (in_ready) rdy_cnt++;
    end

    function automatic int gap_for(input int gm);
        return gm == 0 ? 0 : gm == 1 ? 2 : int'($urandom_range(0, 2));
    endfunction

    task automatic send(input logic [7:0] w, input int gap);
        int n = 0;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = w;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [7:0] base, input logic [7:0] csum, input int gm);
        int         n = pl.size();
        logic [7:0] sum = 8'h00, tot;
        logic       good;
        foreach (pl[i]) sum += pl[i];
        tot  = sum + csum;
        good = (tot == 8'h00);
        got_a.delete();
        got_d.delete();
        in_valid = 1'b0;
        rdy_cnt  = 0;
        pulse_start();
        checks++;
        if ({busy, done, err} !== 3'b100) $display("FAIL %s_armed: busy/done/err=%b required 100", nm, {busy, done, err});
        else passed++;
        send(8'(n), gap_for(gm));
        send(base, gap_for(gm));
        foreach (pl[i]) send(pl[i], gap_for(gm));
        send(csum, gap_for(gm));
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (got_a.size() !== n) $display("FAIL %s_write_count: got %0d required %0d", nm, got_a.size(), n);
        else passed++;
        for (int k = 0; k < n && k < got_a.size(); k++) begin
            checks++;
            if ({got_a[k], got_d[k]} !== {8'(int'(base) + k), pl[k]})
                $display("FAIL %s_write%0d: addr/data=%h/%h required %h/%h", nm, k, got_a[k], got_d[k], 8'(int'(base) + k), pl[k]);
            else passed++;
        end
        checks++;
        if ({done, err, busy} !== {good, !good, 1'b0})
            $display("FAIL %s_status: done/err/busy=%b required %b", nm, {done, err, busy}, {good, !good, 1'b0});
        else passed++;
        if (gm == 0) begin
            checks++;
            if (rdy_cnt !== n + 3) $display("FAIL %s_ready_cycles: got %0d required %0d", nm, rdy_cnt, n + 3);
            else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({in_ready, ram_we, busy, done, err, ram_addr, ram_din} !== 21'd0)
            $display("FAIL reset: outputs=%h required 0", {in_ready, ram_we, busy, done, err, ram_addr, ram_din});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pl = '{8'hAA, 8'h55, 8'h01};
        run_frame("good", 8'h10, 8'h00, 0);
        run_frame("bad_csum", 8'h10, 8'h01, 0);
        pl = '{8'h11, 8'h22, 8'h33};
        run_frame("wrap", 8'hFE, 8'h9A, 0);
        pl = '{8'hAA, 8'h55, 8'h01};
        run_frame("gaps", 8'h10, 8'h00, 1);
    endtask

    task automatic test_full_memory();
        logic [7:0] s = 8'h00;
        pl.delete();
        for (int i = 0; i < 256; i++) begin
            pl.push_back(8'(i));
            s += 8'(i);
        end
        run_frame("full", 8'h00, 8'(-s), 0);
        checks++;
        if (mem[200] !== 8'd200 || mem[0] !== 8'd0 || mem[255] !== 8'd255)
            $display("FAIL full_mem: mem[0/200/255]=%h/%h/%h required 00/c8/ff", mem[0], mem[200], mem[255]);
        else passed++;
    endtask

    task automatic test_rst_mid();
        foreach (mem[i]) mem[i] = 8'h00;
        got_a.delete();
        got_d.delete();
        pulse_start();
        send(8'h03, 0);
        send(8'h10, 0);
        send(8'hAA, 0);
        send(8'h55, 0);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({in_ready, ram_we, busy, done, err, ram_addr, ram_din} !== 21'd0)
            $display("FAIL rst_mid_outputs: outputs=%h required 0", {in_ready, ram_we, busy, done, err, ram_addr, ram_din});
        else passed++;
        checks++;
        if ({mem[8'h10], mem[8'h11], mem[8'h12]} !== 24'hAA5500)
            $display("FAIL rst_mid_mem: mem[10..12]=%h %h %h required AA 55 00", mem[8'h10], mem[8'h11], mem[8'h12]);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        send(8'h03, 0);
        send(8'h10, 0);
        in_valid = 1'b0;
        pulse_start();
        #1;
        checks++;
        if ({busy, in_ready, done} !== 3'b110) $display("FAIL start_ignored: busy/in_ready/done=%b required 110", {busy, in_ready, done});
        else passed++;
        send(8'hAA, 0);
        send(8'h55, 0);
        send(8'h01, 0);
        send(8'h00, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({done, err, got_a.size()} !== {2'b10, 32'd5})
            $display("FAIL start_ignored_finish: done/err=%b writes=%0d required 10 and 5", {done, err}, got_a.size());
        else passed++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            int         n = $urandom_range(1, 20);
            logic [7:0] s = 8'h00, cs;
            pl.delete();
            for (int i = 0; i < n; i++) begin
                pl.push_back(8'($urandom));
                s += pl[i];
            end
            cs = ($urandom_range(0, 1) == 1) ? 8'(-s) : 8'(-s) + 8'($urandom_range(1, 255));
            run_frame($sformatf("rand%0d", f), 8'($urandom), cs, 2);
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 8'h00;
        test_reset();
        test_basic();
        test_full_memory();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
